// File: rtl/blowfish_round_engine.sv
// Iterative 16-round Blowfish Feistel controller driving an external F stage; define BLOWFISH_DECRYPT_EN for a decrypt port.
// Latency 16*(F_LATENCY+2)+1 edges from accept to out_valid; one block in flight, out_valid held until out_ready.
module blowfish_round_engine #(
    parameter int F_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef BLOWFISH_DECRYPT_EN
    input  logic        decrypt,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    input  logic        p_we,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] f_in,
    input  logic [31:0] f_out,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, XORP, WAIT, MIX, FINAL, DONE} state_t;

    localparam logic [2:0] WLAST = (F_LATENCY > 0) ? 3'(F_LATENCY - 1) : 3'd0;

    state_t      state;
    logic [31:0] xl, xr;
    logic [3:0]  rnd;
    logic [2:0]  wcnt;
    logic [31:0] p [0:17];
    logic [4:0]  pidx, pfin_l, pfin_r;

`ifdef BLOWFISH_DECRYPT_EN
    logic dec;

    // Decryption walks the P-array backwards and swaps the final whitening pair.
    always_comb begin
        pidx   = dec ? (5'd17 - {1'b0, rnd}) : {1'b0, rnd};
        pfin_r = dec ? 5'd1 : 5'd16;
        pfin_l = dec ? 5'd0 : 5'd17;
    end
`else
    assign pidx   = {1'b0, rnd};
    assign pfin_r = 5'd16;
    assign pfin_l = 5'd17;
`endif

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign f_in     = xl;

    // P-array is deliberately left out of reset so a reset keeps the loaded key.
    always_ff @(posedge clk) begin
        if (state == IDLE && p_we && p_addr <= 5'd17)
            p[p_addr] <= p_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_block <= 64'd0;
            xl        <= 32'd0;
            xr        <= 32'd0;
            rnd       <= 4'd0;
            wcnt      <= 3'd0;
`ifdef BLOWFISH_DECRYPT_EN
            dec       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xl    <= in_block[63:32];
                        xr    <= in_block[31:0];
                        rnd   <= 4'd0;
`ifdef BLOWFISH_DECRYPT_EN
                        dec   <= decrypt;
`endif
                        state <= XORP;
                    end
                end
                XORP: begin
                    xl    <= xl ^ p[pidx];
                    wcnt  <= 3'd0;
                    state <= (F_LATENCY == 0) ? MIX : WAIT;
                end
                WAIT: begin
                    if (wcnt == WLAST)
                        state <= MIX;
                    else
                        wcnt <= wcnt + 3'd1;
                end
                MIX: begin
                    xl <= xr ^ f_out;
                    xr <= xl;
                    if (rnd == 4'd15) begin
                        state <= FINAL;
                    end else begin
                        rnd   <= rnd + 4'd1;
                        state <= XORP;
                    end
                end
                FINAL: begin
                    // Undoing the last swap puts xR in the left half and xL in the right half.
                    out_block <= {xr ^ p[pfin_l], xl ^ p[pfin_r]};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blowfish_round_engine.sv
// Self-checking bench for blowfish_round_engine against a textbook Blowfish reference model.
module tb_blowfish_round_engine;

    localparam int FL  = 1;
    localparam int FLI = (FL > 0) ? FL - 1 : 0;
    localparam int LAT = 16 * (FL + 2) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;
    logic        p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_wdata;
    logic [31:0] f_in;
    logic [31:0] f_out;
    logic        busy;
`ifdef BLOWFISH_DECRYPT_EN
    logic        decrypt;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          fsel  = 0;
    logic [31:0] pm [0:17];
    logic [31:0] fd [0:7];

    always #5 clk = ~clk;

    blowfish_round_engine #(.F_LATENCY(FL)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef BLOWFISH_DECRYPT_EN
        .decrypt   (decrypt),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .p_we      (p_we),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .f_in      (f_in),
        .f_out     (f_out),
        .busy      (busy)
    );

    function automatic logic [31:0] ffun(input logic [31:0] x, input int sel);
        case (sel)
            0:       return x;
            1:       return 32'd0;
            2:       return {x[28:0], x[31:29]} ^ x;
            default: return (x * 32'h9E3779B1) ^ {x[15:0], x[31:16]};
        endcase
    endfunction

    // F stage model: F applied to f_in as it was FL edges ago.
    always @(posedge clk) begin
        fd[0] <= f_in;
        for (int k = 1; k < 8; k++) fd[k] <= fd[k-1];
    end
    assign f_out = ffun((FL == 0) ? f_in : fd[FLI], fsel);

    function automatic logic [63:0] model(input logic [63:0] blk, input bit dec);
        logic [31:0] l, r, t;
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < 16; i++) begin
            l = l ^ pm[dec ? 17 - i : i];
            r = r ^ ffun(l, fsel);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ pm[dec ? 1 : 16];
        l = l ^ pm[dec ? 0 : 17];
        return {l, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic p_write(input logic [4:0] a, input logic [31:0] d);
        p_we = 1'b1; p_addr = a; p_wdata = d;
        cyc(1);
        p_we = 1'b0;
        if (a <= 5'd17) pm[a] = d;
    endtask

    task automatic load_all(input logic [31:0] d);
        for (int i = 0; i < 18; i++) p_write(5'(i), d);
    endtask

    task automatic start_block(input logic [63:0] blk, input bit dec);
        int g;
        g = 0;
        in_block = blk;
`ifdef BLOWFISH_DECRYPT_EN
        decrypt = dec;
`else
        if (dec) $display("decrypt requested without BLOWFISH_DECRYPT_EN");
`endif
        while (!in_ready && g < 200) begin
            cyc(1);
            g++;
        end
        if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [63:0] exp, input int elapsed);
        int lat;
        lat = elapsed;
        while (!out_valid && lat < LAT + 50) begin
            cyc(1);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        chk(tag, out_block, exp);
    endtask

    task automatic release_out(input string tag, input int d);
        out_ready = 1'b0;
        cyc(d);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk({tag, "_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] blk, blk2, ct;
        bit          seen;

        rst = 1'b1; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
        p_we = 1'b0; p_addr = '0; p_wdata = '0;
`ifdef BLOWFISH_DECRYPT_EN
        decrypt = 1'b0;
`endif
        cyc(2);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_block", out_block, 64'd0);
        chk("rst_f_in", 64'(f_in), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        cyc(1);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Zero key, identity F.
        fsel = 0;
        load_all(32'd0);
        start_block(64'h00000001_00000002, 1'b0);
        wait_out("t1", 64'h00000001_00000003, 0);
        release_out("t1", 0);

        // Uniform key, zero F.
        fsel = 1;
        load_all(32'h11111111);
        start_block(64'hAAAAAAAA_55555555, 1'b0);
        wait_out("t2", 64'h44444444_BBBBBBBB, 0);
        release_out("t2", 0);

        // Output held under backpressure; a waiting block is not taken early.
        blk2 = 64'h0F0F0F0F_F0F0F0F0;
        start_block(64'hAAAAAAAA_55555555, 1'b0);
        wait_out("t3a", 64'h44444444_BBBBBBBB, 0);
        in_block = blk2;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_block", out_block, 64'h44444444_BBBBBBBB);
            chk("t3_hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("t3_after_hs_ready", 64'(in_ready), 64'd1);
        chk("t3_after_hs_busy", 64'(busy), 64'd0);
        cyc(1);
        in_valid = 1'b0;
        chk("t3_second_accepted", 64'(busy), 64'd1);
        wait_out("t3b", model(blk2, 1'b0), 0);
        release_out("t3b", 0);

        // Reset in round 7 aborts the block but keeps the key.
        start_block(64'h01234567_89ABCDEF, 1'b0);
        cyc(7 * (FL + 2) + 1);
        rst = 1'b1;
        #1;
        chk("t4_ready_in_rst", 64'(in_ready), 64'd0);
        cyc(1);
        rst = 1'b0;
        #1;
        chk("t4_busy_after_rst", 64'(busy), 64'd0);
        chk("t4_ready_after_rst", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < LAT + 10; c++) begin
            cyc(1);
            if (out_valid) seen = 1'b1;
        end
        chk("t4_no_out_valid", 64'(seen), 64'd0);
        start_block(64'hAAAAAAAA_55555555, 1'b0);
        wait_out("t4_rerun", 64'h44444444_BBBBBBBB, 0);
        release_out("t4_rerun", 0);

        // P writes while busy or out of range are dropped.
        start_block(64'hAAAAAAAA_55555555, 1'b0);
        p_we = 1'b1; p_addr = 5'd0; p_wdata = 32'hDEADBEEF;
        cyc(1);
        p_we = 1'b0;
        wait_out("t5_busy_we", 64'h44444444_BBBBBBBB, 1);
        release_out("t5_busy_we", 0);
        p_write(5'd20, 32'hCAFEF00D);
        start_block(64'hAAAAAAAA_55555555, 1'b0);
        wait_out("t5_addr20", 64'h44444444_BBBBBBBB, 0);
        release_out("t5_addr20", 0);

        // Write and accept on the same idle edge: the new P[0] is used.
        fsel = 3;
        blk = {$urandom, $urandom};
        p_we = 1'b1; p_addr = 5'd0; p_wdata = 32'h12345678;
        in_block = blk; in_valid = 1'b1;
        cyc(1);
        p_we = 1'b0; in_valid = 1'b0;
        pm[0] = 32'h12345678;
        wait_out("same_edge", model(blk, 1'b0), 0);
        release_out("same_edge", 1);

        // Random key, nonlinear F, random blocks and backpressure.
        for (int i = 0; i < 18; i++) p_write(5'(i), $urandom);
        for (int n = 0; n < 6; n++) begin
            blk = {$urandom, $urandom};
            start_block(blk, 1'b0);
            wait_out("rand", model(blk, 1'b0), 0);
            release_out("rand", int'($urandom_range(0, 3)));
        end

`ifdef BLOWFISH_DECRYPT_EN
        fsel = 2;
        for (int i = 0; i < 18; i++) p_write(5'(i), $urandom);
        blk = 64'h01234567_89ABCDEF;
        start_block(blk, 1'b0);
        wait_out("enc", model(blk, 1'b0), 0);
        ct = out_block;
        release_out("enc", 0);
        start_block(ct, 1'b1);
        wait_out("dec_model", model(ct, 1'b1), 0);
        chk("dec_roundtrip", out_block, 64'h01234567_89ABCDEF);
        release_out("dec", 0);
`else
        ct = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
